// File: rtl/nms_stage.sv
// nms_stage: Canny non-maximum suppression over a 3x3 window of {dir,mag} gradients.
// Defining NMS_STATS_EN adds edge_count, the number of nonzero output pixels in the last frame.
module nms_stage #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err
`ifdef NMS_STATS_EN
  ,
  output logic [31:0] edge_count
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);
  typedef enum logic [1:0] {S_FILL, S_RUN, S_EOL, S_FLUSH} state_t;
  state_t state;
  logic [CW-1:0] col, rd;
  logic [RW-1:0] row;
  logic [14:0] lb0 [IMG_WIDTH];
  logic [14:0] lb1 [IMG_WIDTH];
  logic [14:0] w [3][3];
  logic [14:0] nw [3][3];
  logic [14:0] lc [3];
  logic [11:0] nm [3][3];
  logic [11:0] n0, n1, mag;
  logic [1:0] dsel;
  logic accept_st, step, do_step, last_col, pad, emit, west_mask, flush0;
  logic [7:0] pix;

  // nw is the window after this step; its centre is the pixel being emitted
  always_comb begin
    accept_st = state == S_FILL || state == S_RUN;
    step = !m_axis_tvalid || m_axis_tready;
    do_step = step && (!accept_st || s_axis_tvalid);
    last_col = col == LAST_C;
    pad = state == S_EOL || (state == S_FLUSH && last_col);
    flush0 = state == S_FLUSH && col == '0;
    rd = state == S_FLUSH ? (last_col ? '0 : col + 1'b1) : col;
    lc[0] = (pad || (accept_st && row <= RW'(1))) ? '0 : lb1[rd];
    lc[1] = (pad || (accept_st && row == '0)) ? '0 : lb0[rd];
    lc[2] = accept_st ? s_axis_tdata : '0;
    west_mask = state == S_RUN && col == CW'(1);
    for (int i = 0; i < 3; i++) begin
      nw[i][0] = flush0 ? '0 : w[i][1];
      nw[i][1] = flush0 ? (i == 0 ? lb1[0] : i == 1 ? lb0[0] : '0) : w[i][2];
      nw[i][2] = lc[i];
      for (int j = 0; j < 3; j++) nm[i][j] = (j == 0 && west_mask) ? '0 : nw[i][j][11:0];
    end
    mag = nm[1][1];
    dsel = 2'(nw[1][1][14:12] % 3'd4);
    n0 = dsel == 2'd0 ? nm[1][0] : dsel == 2'd1 ? nm[0][2] : dsel == 2'd2 ? nm[0][1] : nm[0][0];
    n1 = dsel == 2'd0 ? nm[1][2] : dsel == 2'd1 ? nm[2][0] : dsel == 2'd2 ? nm[2][1] : nm[2][2];
    pix = (mag >= n0 && mag > n1) ? (mag > 12'd255 ? 8'hff : mag[7:0]) : 8'h00;
    emit = state == S_EOL || state == S_FLUSH || (state == S_RUN && col != '0);
  end

  assign s_axis_tready = !reset && step && accept_st;

  always_ff @(posedge clk) begin
    if (do_step) w <= nw;
    if (do_step && accept_st) begin
      lb1[col] <= lb0[col];
      lb0[col] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FILL;
      row <= '0;
      col <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (do_step && accept_st && s_axis_tlast != (row == LAST_R && last_col)) frame_err <= 1'b1;
      if (do_step) begin
        m_axis_tvalid <= emit;
        m_axis_tdata <= emit ? pix : '0;
        m_axis_tlast <= state == S_FLUSH && last_col;
        if (accept_st) begin
          col <= last_col ? '0 : col + 1'b1;
          if (last_col && row == '0) row <= RW'(1);
          else if (last_col) state <= S_EOL;
          else if (state == S_FILL && row == RW'(1)) state <= S_RUN;
        end else if (state == S_EOL) begin
          state <= row == LAST_R ? S_FLUSH : S_RUN;
          row <= row == LAST_R ? row : row + 1'b1;
        end else begin
          col <= last_col ? '0 : col + 1'b1;
          state <= last_col ? S_FILL : S_FLUSH;
          row <= last_col ? '0 : row;
        end
      end
    end
  end

`ifdef NMS_STATS_EN
  logic [31:0] ecnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      ecnt <= '0;
      edge_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      ecnt <= m_axis_tlast ? '0 : ecnt + 32'(m_axis_tdata != '0);
      if (m_axis_tlast) edge_count <= ecnt + 32'(m_axis_tdata != '0);
    end
  end
`endif
endmodule

// File: tb/tb_nms_stage.sv
// tb_nms_stage: directed and randomised-handshake checks of nms_stage against a frame-level NMS model.
module tb_nms_stage;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  logic clk = 0, reset = 1;
  logic [14:0] s_tdata = '0;
  logic s_tvalid = 0, s_tlast = 0, s_tready;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 0, m_tlast, frame_err;
`ifdef NMS_STATS_EN
  logic [31:0] edge_count;
`endif
  int checks = 0, passed = 0;
  logic [11:0] fm [N];
  logic [2:0] fd [N];
  logic [7:0] got_d [N];
  logic got_l [N];
  int got_n, stall_bad;

  nms_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .frame_err(frame_err)
`ifdef NMS_STATS_EN
    , .edge_count(edge_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int mg(int r, int c);
    return (r < 0 || r >= H || c < 0 || c >= W) ? 0 : int'(fm[r * W + c]);
  endfunction

  function automatic logic [7:0] model(int r, int c);
    int m, n0, n1;
    logic [2:0] d;
    m = mg(r, c);
    d = fd[r * W + c];
    case (d[1:0])
      2'd0: begin n0 = mg(r, c - 1); n1 = mg(r, c + 1); end
      2'd1: begin n0 = mg(r - 1, c + 1); n1 = mg(r + 1, c - 1); end
      2'd2: begin n0 = mg(r - 1, c); n1 = mg(r + 1, c); end
      default: begin n0 = mg(r - 1, c - 1); n1 = mg(r + 1, c + 1); end
    endcase
    return (m >= n0 && m > n1) ? ((m > 255) ? 8'd255 : 8'(m)) : 8'd0;
  endfunction

  task automatic clear_frame;
    for (int i = 0; i < N; i++) begin fm[i] = '0; fd[i] = '0; end
  endtask

  task automatic rand_frame;
    for (int i = 0; i < N; i++) begin
      fm[i] = 12'($urandom_range(0, 1023));
      fd[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // Called at posedge+1; drives one frame and collects outputs, checking hold-under-stall.
  task automatic run_frame(input int gap_pct, input int rdy_pct, input int tlast_at);
    got_n = 0;
    stall_bad = 0;
    fork
      begin : drv
        for (int i = 0; i < N; i++) begin
          while ($urandom_range(0, 99) < gap_pct) begin s_tvalid = 0; @(posedge clk); #1; end
          s_tvalid = 1;
          s_tdata = {fd[i], fm[i]};
          s_tlast = (i == tlast_at);
          @(negedge clk);
          for (int t = 0; !s_tready && t < 2000; t++) @(negedge clk);
          @(posedge clk); #1;
        end
        s_tvalid = 0;
        s_tlast = 0;
      end
      begin : mon
        logic pv;
        logic [7:0] pd;
        logic pl;
        pv = 0;
        pd = '0;
        pl = 0;
        for (int cyc = 0; got_n < N && cyc < 4000; cyc++) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 99) < rdy_pct);
          @(negedge clk);
          if (pv && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stall_bad++;
          pv = m_tvalid && !m_tready;
          pd = m_tdata;
          pl = m_tlast;
          if (m_tvalid && m_tready) begin got_d[got_n] = m_tdata; got_l[got_n] = m_tlast; got_n++; end
        end
      end
    join
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 0 || m_tdata !== 0 || m_tlast !== 0 || frame_err !== 0 || s_tready !== 0)
      $display("FAIL reset outputs: got v%b d%0d l%b e%b r%b, want all 0", m_tvalid, m_tdata, m_tlast, frame_err, s_tready);
    else passed++;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1) $display("FAIL reset tready: got %b want 1", s_tready);
    else passed++;
  endtask

  task automatic test_zero;
    int extra = 0;
    clear_frame();
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (got_n !== N) $display("FAIL zero count: got %0d want %0d", got_n, N); else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_d[i] !== 0 || got_l[i] !== (i == N - 1))
        $display("FAIL zero pix %0d: got d%0d l%b want d0 l%b", i, got_d[i], got_l[i], i == N - 1);
      else passed++;
    end
    checks++;
    if (frame_err !== 0) $display("FAIL zero frame_err: got %b want 0", frame_err); else passed++;
    repeat (10) begin @(negedge clk); if (m_tvalid) extra++; end
    checks++;
    if (extra !== 0) $display("FAIL zero extra beats: got %0d want 0", extra); else passed++;
  endtask

  task automatic test_ridge;
    clear_frame();
    for (int r = 0; r < H; r++) begin fm[r * W + 2] = 50; fm[r * W + 3] = 100; fm[r * W + 4] = 50; end
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (got_n !== N || got_d[2 * W + 3] !== 100 || got_d[2 * W + 2] !== 0 || got_d[2 * W + 4] !== 0)
      $display("FAIL ridge row2: got n%0d c2=%0d c3=%0d c4=%0d want n64 0 100 0", got_n, got_d[2 * W + 2], got_d[2 * W + 3], got_d[2 * W + 4]);
    else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_d[i] !== model(i / W, i % W))
        $display("FAIL ridge pix %0d: got %0d want %0d", i, got_d[i], model(i / W, i % W));
      else passed++;
    end
  endtask

  task automatic test_plateau;
    clear_frame();
    for (int c = 0; c < W; c++) fm[3 * W + c] = 80;
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (got_d[3 * W] !== 0 || got_d[3 * W + 7] !== 80 || got_d[3 * W + 4] !== 0)
      $display("FAIL plateau: got c0=%0d c4=%0d c7=%0d want 0 0 80", got_d[3 * W], got_d[3 * W + 4], got_d[3 * W + 7]);
    else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_d[i] !== model(i / W, i % W))
        $display("FAIL plateau pix %0d: got %0d want %0d", i, got_d[i], model(i / W, i % W));
      else passed++;
    end
  endtask

  task automatic test_saturation;
    clear_frame();
    fm[4 * W + 4] = 700;
    fd[4 * W + 4] = 2;
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (got_d[4 * W + 4] !== 255) $display("FAIL sat isolated: got %0d want 255", got_d[4 * W + 4]); else passed++;
    fm[5 * W + 4] = 701;
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (got_d[4 * W + 4] !== 0 || got_d[5 * W + 4] !== 255)
      $display("FAIL sat suppressed: got %0d,%0d want 0,255", got_d[4 * W + 4], got_d[5 * W + 4]);
    else passed++;
  endtask

  task automatic test_random_stall;
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      @(posedge clk); #1;
      run_frame(30, 50, N - 1);
      checks++;
      if (got_n !== N || stall_bad !== 0)
        $display("FAIL random f%0d: got n%0d stall_err%0d want n64 stall_err0", f, got_n, stall_bad);
      else passed++;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got_d[i] !== model(i / W, i % W) || got_l[i] !== (i == N - 1))
          $display("FAIL random f%0d pix %0d: got d%0d l%b want d%0d l%b", f, i, got_d[i], got_l[i], model(i / W, i % W), i == N - 1);
        else passed++;
      end
    end
  endtask

  task automatic test_tlast_err;
    rand_frame();
    @(posedge clk); #1;
    run_frame(0, 100, 30);
    checks++;
    if (frame_err !== 1 || got_n !== N || got_l[30] !== 0 || got_l[N - 1] !== 1)
      $display("FAIL tlast_err: got e%b n%0d l30=%b l63=%b want e1 n64 l30=0 l63=1", frame_err, got_n, got_l[30], got_l[N - 1]);
    else passed++;
    @(posedge clk); #1;
    run_frame(0, 100, N - 1);
    checks++;
    if (frame_err !== 1 || got_n !== N) $display("FAIL tlast_err sticky: got e%b n%0d want e1 n64", frame_err, got_n);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    rand_frame();
    @(posedge clk); #1;
    m_tready = 1;
    for (int cyc = 0; k < 20 && cyc < 200; cyc++) begin
      s_tvalid = 1;
      s_tdata = {fd[k], fm[k]};
      s_tlast = 0;
      @(negedge clk);
      if (s_tready) k++;
      @(posedge clk); #1;
    end
    s_tvalid = 0;
    checks++;
    if (m_tvalid !== 1) $display("FAIL mid-frame valid: got %b want 1", m_tvalid); else passed++;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 0 || frame_err !== 0) $display("FAIL reset mid: got v%b e%b want v0 e0", m_tvalid, frame_err);
    else passed++;
    @(posedge clk); #1;
    reset = 0;
    rand_frame();
    run_frame(20, 70, N - 1);
    checks++;
    if (got_n !== N || frame_err !== 0 || stall_bad !== 0)
      $display("FAIL post-reset frame: got n%0d e%b stall_err%0d want n64 e0 stall_err0", got_n, frame_err, stall_bad);
    else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_d[i] !== model(i / W, i % W) || got_l[i] !== (i == N - 1))
        $display("FAIL post-reset pix %0d: got d%0d l%b want d%0d l%b", i, got_d[i], got_l[i], model(i / W, i % W), i == N - 1);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ridge();
    test_plateau();
    test_saturation();
    test_random_stall();
    test_tlast_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
